// File: rtl/mag_detect_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mag_detect_frame: per-lane leading-sign counts, then frame min/shift.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mag_detect_frame #(
  parameter  int I_WIDTH = 24,
  parameter  int LANES   = 16,
  parameter  int GUARD   = 1,
  parameter  int BEAT_W  = 10,
  localparam int CNT_W   = $clog2(I_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [I_WIDTH-1:0] din [0:LANES-1],
  output logic               out_valid,
  output logic               out_last,
  output logic [I_WIDTH:0]   dout [0:LANES-1],
  output logic [CNT_W-1:0]   o_cnt [0:LANES-1],
  output logic               o_exp_valid,
  output logic [CNT_W-1:0]   o_min_cnt,
  output logic [CNT_W-1:0]   o_shift,
  output logic [BEAT_W-1:0]  o_beats
);

  localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_IW       = CNT_W'(I_WIDTH);
  localparam logic [CNT_W-1:0]  C_GP1      = CNT_W'(GUARD + 1);
  localparam logic [BEAT_W-1:0] C_BEAT_ONE = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] C_BEAT_MAX = '1;

  // Run length of MSBs matching the sign bit; the sign bit itself counts.
  function automatic logic [CNT_W-1:0] f_lead_cnt(input logic [I_WIDTH-1:0] x);
    logic [CNT_W-1:0] c;
    logic             run;
    c   = C_ONE;
    run = 1'b1;
    for (int k = I_WIDTH - 2; k >= 0; k--) begin
      if (run && (x[k] == x[I_WIDTH-1])) c = c + C_ONE;
      else                                run = 1'b0;
    end
    return c;
  endfunction

  logic               r_out_valid;
  logic               r_out_last;
  logic [I_WIDTH:0]   r_dout [0:LANES-1];
  logic [CNT_W-1:0]   r_cnt  [0:LANES-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_out_last  <= in_valid & in_last;
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_dout[g] <= '0;
          r_cnt[g]  <= '0;
        end else if (in_valid) begin
          r_dout[g] <= {din[g][I_WIDTH-1], din[g]};
          r_cnt[g]  <= f_lead_cnt(din[g]);
        end
      end
      assign dout[g]  = r_dout[g];
      assign o_cnt[g] = r_cnt[g];
    end
  endgenerate

  logic [CNT_W-1:0]  w_lane_min;
  logic [CNT_W-1:0]  w_frame_min;
  logic [CNT_W-1:0]  w_shift;
  logic [BEAT_W-1:0] w_beats_next;

  always_comb begin
    w_lane_min = r_cnt[0];
    for (int k = 1; k < LANES; k++) begin
      if (r_cnt[k] < w_lane_min) w_lane_min = r_cnt[k];
    end
  end

  logic [CNT_W-1:0]  r_acc;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_first;
  logic              r_exp_valid;
  logic [CNT_W-1:0]  r_min_cnt;
  logic [CNT_W-1:0]  r_shift;
  logic [BEAT_W-1:0] r_beats;

  always_comb begin
    w_frame_min = r_first ? w_lane_min
                          : ((r_acc < w_lane_min) ? r_acc : w_lane_min);
    // Keep GUARD headroom bits in front of the normalised sign bit.
    w_shift = (w_frame_min > C_GP1) ? (w_frame_min - C_GP1) : '0;
    if (r_first)                       w_beats_next = C_BEAT_ONE;
    else if (r_beat_cnt == C_BEAT_MAX) w_beats_next = C_BEAT_MAX;
    else                               w_beats_next = r_beat_cnt + C_BEAT_ONE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= C_IW;
      r_beat_cnt  <= '0;
      r_first     <= 1'b1;
      r_exp_valid <= 1'b0;
      r_min_cnt   <= '0;
      r_shift     <= '0;
      r_beats     <= '0;
    end else begin
      r_exp_valid <= 1'b0;
      if (r_out_valid) begin
        if (r_out_last) begin
          r_min_cnt   <= w_frame_min;
          r_shift     <= w_shift;
          r_beats     <= w_beats_next;
          r_exp_valid <= 1'b1;
          r_first     <= 1'b1;
          r_acc       <= C_IW;
        end else begin
          r_acc       <= w_frame_min;
          r_beat_cnt  <= w_beats_next;
          r_first     <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign o_exp_valid = r_exp_valid;
  assign o_min_cnt   = r_min_cnt;
  assign o_shift     = r_shift;
  assign o_beats     = r_beats;

endmodule
`default_nettype wire

// File: tb/tb_mag_detect_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mag_detect_frame: directed stimulus with queued expectations.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mag_detect_frame;

  typedef struct {
    int          lane;
    logic [4:0]  cnt;
    logic [24:0] dv;
    logic        last;
  } beat_t;

  typedef struct {
    logic [4:0] mn;
    logic [4:0] sh;
    logic [9:0] bt;
  } frame_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: 24-bit samples, 16 lanes, GUARD=1
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [23:0] din  [0:15];
  logic        out_valid, out_last, o_exp_valid;
  logic [24:0] dout [0:15];
  logic [4:0]  o_cnt [0:15];
  logic [4:0]  o_min_cnt, o_shift;
  logic [9:0]  o_beats;

  mag_detect_frame #(.I_WIDTH(24), .LANES(16), .GUARD(1), .BEAT_W(10)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_last(in_last), .din(din),
    .out_valid(out_valid), .out_last(out_last), .dout(dout), .o_cnt(o_cnt),
    .o_exp_valid(o_exp_valid), .o_min_cnt(o_min_cnt), .o_shift(o_shift),
    .o_beats(o_beats));

  // Narrow configuration: 16-bit samples, 4 lanes, GUARD=3
  logic        in_valid2 = 1'b0, in_last2 = 1'b0;
  logic [15:0] din2  [0:3];
  logic        out_valid2, out_last2, o_exp_valid2;
  logic [16:0] dout2 [0:3];
  logic [4:0]  o_cnt2 [0:3];
  logic [4:0]  o_min_cnt2, o_shift2;
  logic [9:0]  o_beats2;

  mag_detect_frame #(.I_WIDTH(16), .LANES(4), .GUARD(3), .BEAT_W(10)) u_dut2 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_last(in_last2), .din(din2),
    .out_valid(out_valid2), .out_last(out_last2), .dout(dout2), .o_cnt(o_cnt2),
    .o_exp_valid(o_exp_valid2), .o_min_cnt(o_min_cnt2), .o_shift(o_shift2),
    .o_beats(o_beats2));

  beat_t  bq[$];
  frame_t fq[$];
  frame_t fq2[$];
  int n_cmp = 0;
  int n_err = 0;

  // Value whose leading-sign count is n (n == width gives zero)
  function automatic logic [23:0] mk(input int n);
    logic [23:0] v;
    v = '0;
    if (n < 24) v[23-n] = 1'b1;
    return v;
  endfunction

  function automatic logic [15:0] mk16(input int n);
    logic [15:0] v;
    v = '0;
    if (n < 16) v[15-n] = 1'b1;
    return v;
  endfunction

  task automatic beat(input logic [23:0] v, input int lane, input logic [4:0] c,
                      input logic last);
    for (int k = 0; k < 16; k++) din[k] = '0;
    din[lane] = v;
    in_valid  = 1'b1;
    in_last   = last;
    bq.push_back('{lane, c, {v[23], v}, last});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic beat2(input logic [15:0] v, input int lane, input logic last);
    for (int k = 0; k < 4; k++) din2[k] = '0;
    din2[lane] = v;
    in_valid2  = 1'b1;
    in_last2   = last;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    in_last2  = 1'b0;
  endtask

  task automatic idle(input int n, input logic stray_last);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      in_last  = stray_last;
      @(posedge clk); #1;
    end
    in_last = 1'b0;
  endtask

  task automatic fexp(input logic [4:0] mn, input logic [4:0] sh, input logic [9:0] bt);
    fq.push_back('{mn, sh, bt});
  endtask

  task automatic chk_zero(input string tag);
    logic ok;
    ok = !out_valid && !out_last && !o_exp_valid && o_min_cnt == 0 &&
         o_shift == 0 && o_beats == 0;
    for (int k = 0; k < 16; k++) if (dout[k] != 0 || o_cnt[k] != 0) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: outputs not zero in reset (valid=%b exp=%b min=%0d sh=%0d bt=%0d cnt0=%0d), required all 0",
               tag, out_valid, o_exp_valid, o_min_cnt, o_shift, o_beats, o_cnt[0]);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid) begin
        n_cmp++;
        if (bq.size() == 0) begin
          n_err++;
          $display("FAIL beat_unexpected: out_valid=1 with no beat pending, required none");
        end else begin
          beat_t e;
          logic  ok;
          e = bq.pop_front();
          if (o_cnt[e.lane] !== e.cnt || dout[e.lane] !== e.dv || out_last !== e.last) begin
            n_err++;
            $display("FAIL beat_lane%0d: cnt=%0d dout=%h last=%b, required cnt=%0d dout=%h last=%b",
                     e.lane, o_cnt[e.lane], dout[e.lane], out_last, e.cnt, e.dv, e.last);
          end
          ok = 1'b1;
          for (int k = 0; k < 16; k++)
            if (k != e.lane && (o_cnt[k] !== 5'd24 || dout[k] !== 25'd0)) ok = 1'b0;
          n_cmp++;
          if (!ok) begin
            n_err++;
            $display("FAIL beat_other_lanes: a zero lane shows nonzero dout or cnt, required cnt=24 dout=0");
          end
        end
      end
      if (o_exp_valid) begin
        n_cmp++;
        if (fq.size() == 0) begin
          n_err++;
          $display("FAIL frame_unexpected: o_exp_valid=1 min=%0d beats=%0d, required no pulse",
                   o_min_cnt, o_beats);
        end else begin
          frame_t f;
          f = fq.pop_front();
          if (o_min_cnt !== f.mn || o_shift !== f.sh || o_beats !== f.bt) begin
            n_err++;
            $display("FAIL frame: min=%0d shift=%0d beats=%0d, required min=%0d shift=%0d beats=%0d",
                     o_min_cnt, o_shift, o_beats, f.mn, f.sh, f.bt);
          end
        end
      end
      if (o_exp_valid2) begin
        n_cmp++;
        if (fq2.size() == 0) begin
          n_err++;
          $display("FAIL frame2_unexpected: o_exp_valid=1 min=%0d, required no pulse", o_min_cnt2);
        end else begin
          frame_t f;
          f = fq2.pop_front();
          if (o_min_cnt2 !== f.mn || o_shift2 !== f.sh || o_beats2 !== f.bt) begin
            n_err++;
            $display("FAIL frame2: min=%0d shift=%0d beats=%0d, required min=%0d shift=%0d beats=%0d",
                     o_min_cnt2, o_shift2, o_beats2, f.mn, f.sh, f.bt);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 16; k++) din[k] = '0;
    for (int k = 0; k < 4; k++) din2[k] = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset_initial");
    @(posedge clk); #1;
    rstn = 1'b1;

    // All-zero single-beat frame
    fexp(5'd24, 5'd22, 10'd1);
    beat(24'h000000, 0, 5'd24, 1'b1);
    idle(2, 1'b0);

    // Count sweep across lanes, one frame of six beats
    beat(24'h000001, 0,  5'd23, 1'b0);
    beat(24'hFFFFFF, 3,  5'd24, 1'b0);
    beat(24'h7FFFFF, 7,  5'd1,  1'b0);
    beat(24'h800000, 9,  5'd1,  1'b0);
    beat(24'h000FFF, 12, 5'd12, 1'b0);
    fexp(5'd1, 5'd0, 10'd6);
    beat(24'hFFF000, 15, 5'd12, 1'b1);
    idle(2, 1'b0);

    // Four beats with a gap carrying a stray in_last
    beat(mk(20), 2,  5'd20, 1'b0);
    beat(mk(15), 11, 5'd15, 1'b0);
    idle(2, 1'b1);
    beat(mk(18), 4,  5'd18, 1'b0);
    fexp(5'd15, 5'd13, 10'd4);
    beat(mk(22), 15, 5'd22, 1'b1);
    idle(2, 1'b0);

    // Back-to-back frames: A min 5, B min 19
    beat(mk(8), 1, 5'd8, 1'b0);
    fexp(5'd5, 5'd3, 10'd2);
    beat(mk(5), 6, 5'd5, 1'b1);
    beat(mk(19), 8,  5'd19, 1'b0);
    beat(mk(21), 13, 5'd21, 1'b0);
    fexp(5'd19, 5'd17, 10'd3);
    beat(mk(22), 0,  5'd22, 1'b1);
    idle(2, 1'b0);

    // Partial frame discarded by reset
    beat(mk(2),  5,  5'd2,  1'b0);
    beat(mk(10), 10, 5'd10, 1'b0);
    beat(mk(20), 14, 5'd20, 1'b0);
    idle(1, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("reset_midframe_a");
    @(negedge clk);
    chk_zero("reset_midframe_b");
    @(posedge clk); #1;
    rstn = 1'b1;
    fexp(5'd17, 5'd15, 10'd1);
    beat(mk(17), 3, 5'd17, 1'b1);
    idle(2, 1'b0);

    // Beat counter saturation
    for (int i = 0; i < 1030; i++) begin
      if (i == 1029) fexp(5'd24, 5'd22, 10'd1023);
      beat(24'h000000, 0, 5'd24, i == 1029);
    end
    idle(2, 1'b0);

    // Narrow instance: GUARD=3 clamp and boundaries
    fq2.push_back('{5'd2, 5'd0, 10'd1});
    beat2(mk16(2), 1, 1'b1);
    fq2.push_back('{5'd16, 5'd12, 10'd1});
    beat2(16'h0000, 0, 1'b1);
    fq2.push_back('{5'd5, 5'd1, 10'd1});
    beat2(mk16(5), 3, 1'b1);
    beat2(mk16(4), 2, 1'b0);
    fq2.push_back('{5'd4, 5'd0, 10'd2});
    beat2(16'hFFFF, 0, 1'b1);

    for (int t = 0; t < 50; t++) begin
      if (bq.size() == 0 && fq.size() == 0 && fq2.size() == 0) break;
      @(posedge clk); #1;
    end
    idle(3, 1'b0);
    n_cmp++;
    if (bq.size() != 0 || fq.size() != 0 || fq2.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending beats=%0d frames=%0d frames2=%0d, required 0/0/0",
               bq.size(), fq.size(), fq2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mag_detect_frame.md
Name: mag_detect_frame

Overview:
Streaming block-floating-point magnitude detector for the FFT datapath. Each valid beat carries LANES signed samples. For every sample the block registers a sign-extended copy and its leading-sign-bit count. Across each frame (delimited by in_last) it tracks the minimum count over all lanes and beats, then reports the frame's shared exponent and normalisation shift for the following scaling stage.

Parameters:
I_WIDTH, 24, sample width in bits (signed two's complement), >= 2
LANES, 16, samples per beat
GUARD, 1, guard bits kept when computing o_shift, 0..I_WIDTH-1
BEAT_W, 10, width of the per-frame beat counter
CNT_W, $clog2(I_WIDTH+1), width of the count fields (derived, not overridden)

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
in_valid  in  1  beat qualifier; no backpressure, gaps allowed
in_last  in  1  last beat of frame; meaningful only with in_valid
din  in  [I_WIDTH-1:0] x LANES  signed samples, unpacked [0:LANES-1]
out_valid  out  1  registered in_valid
out_last  out  1  registered in_valid & in_last
dout  out  [I_WIDTH:0] x LANES  sign-extended registered samples
o_cnt  out  [CNT_W-1:0] x LANES  per-lane leading-sign count
o_exp_valid  out  1  one-cycle pulse: frame result valid
o_min_cnt  out  [CNT_W-1:0]  frame minimum count
o_shift  out  [CNT_W-1:0]  normalisation shift for the frame
o_beats  out  [BEAT_W-1:0]  beats in the closed frame, saturating

Behaviour:
- Reset: all outputs are 0. The accumulator is I_WIDTH. The first-beat flag is 1. The beat counter is 0. Asserting reset mid-frame discards the partial frame; the next valid beat starts a new frame.
- Count definition: cnt(x) = number of consecutive MSBs of x equal to x[I_WIDTH-1], sign bit included.
  - Range is 1..I_WIDTH.
  - 0 and all-ones give I_WIDTH.
  - 0 is never produced.
- Stage 1 (latency 1), on each clk edge:
  - out_valid <= in_valid
  - out_last <= in_valid & in_last
  - When in_valid: dout[i] <= {din[i][MSB], din[i]} and o_cnt[i] <= cnt(din[i]).
  - When !in_valid: dout and o_cnt hold.
- Stage 2 (lane reduction plus accumulation):
  - lane_min = combinational minimum of o_cnt[0..LANES-1].
  - On an out_valid cycle: frame_min = first ? lane_min : min(acc, lane_min).
  - Beat count: beats_next = first ? 1 : sat(beat_cnt + 1), saturating at 2^BEAT_W-1.
  - out_valid & !out_last: acc <= frame_min, beat_cnt <= beats_next, first <= 0.
  - out_valid & out_last: the closing beat is included. Register o_min_cnt <= frame_min, o_shift <= max(frame_min - 1 - GUARD, 0), o_beats <= beats_next. Pulse o_exp_valid for one cycle. Set first <= 1 and acc <= I_WIDTH.
  - !out_valid: state holds.
  - o_exp_valid is 0 in every other cycle. Frame outputs hold until the next frame closes.
- Latency: o_exp_valid rises 2 clk after the in_last beat is sampled, i.e. 1 clk after out_last.
- Single-beat frame (in_last on the first beat): o_min_cnt = that beat's lane_min and o_beats = 1.
- Back-to-back frames (in_last followed immediately by a valid beat): the new beat starts a fresh frame. No value carries over from the prior frame.
- in_last without in_valid is ignored.
- No frame output is produced until in_last arrives; there is no timeout.

Test Plan:
- Reset then 1 beat: all din = 0, in_last=1 -> next cycle o_cnt[i]=24 and dout[i]=0; following cycle o_exp_valid=1, o_min_cnt=24, o_shift=22, o_beats=1.
- Count sweep, one lane per beat: din=24'h000001 -> 23; 24'hFFFFFF -> 24; 24'h7FFFFF -> 1; 24'h800000 -> 1; 24'h000FFF -> 12; 24'hFFF000 -> 12. Check dout[i]=25'h1FFF000 for the last value.
- 4-beat frame with a 2-cycle gap between beats 2 and 3; lane mins 20,15,18,22 -> o_min_cnt=15, o_shift=13, o_beats=4, and exactly one o_exp_valid pulse.
- Back-to-back frames: frame A min 5 (2 beats), then frame B min 19 (3 beats) with no idle cycle -> A reports 5 with o_beats=2, B reports 19 with o_beats=3 (not 5).
- Reset mid-frame: apply 3 beats with min 2, pulse rstn low, then a 1-beat frame with min 17 -> o_min_cnt=17, o_beats=1; all outputs are 0 during reset.
- GUARD=3, I_WIDTH=16: frame min 2 -> o_shift=0 (clamped). Frame of all zeros -> o_min_cnt=16, o_shift=12.
